// File: rtl/axi4_to_alrdwr_if.sv
// Signal bundle between an AXI4 master and the AL read/write channel pair.
// 'slave' is the bridge's view; 'master' is the view of the surrounding environment.
interface axi4_to_alrdwr_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_BITS  = 2,
  parameter int ID_WIDTH   = 4
) ();
  localparam int DATA_WIDTH = 8 << DATA_BITS;

  logic [ADDR_WIDTH-1:0]         s_axi_awaddr;
  logic [ID_WIDTH-1:0]           s_axi_awid;
  logic [7:0]                    s_axi_awlen;
  logic [1:0]                    s_axi_awburst;
  logic                          s_axi_awvalid;
  logic                          s_axi_awready;
  logic [DATA_WIDTH-1:0]         s_axi_wdata;
  logic                          s_axi_wlast;
  logic                          s_axi_wvalid;
  logic                          s_axi_wready;
  logic [ID_WIDTH-1:0]           s_axi_bid;
  logic [1:0]                    s_axi_bresp;
  logic                          s_axi_bvalid;
  logic                          s_axi_bready;
  logic [ADDR_WIDTH-1:0]         s_axi_araddr;
  logic [ID_WIDTH-1:0]           s_axi_arid;
  logic [7:0]                    s_axi_arlen;
  logic [1:0]                    s_axi_arburst;
  logic                          s_axi_arvalid;
  logic                          s_axi_arready;
  logic [DATA_WIDTH-1:0]         s_axi_rdata;
  logic [ID_WIDTH-1:0]           s_axi_rid;
  logic [1:0]                    s_axi_rresp;
  logic                          s_axi_rlast;
  logic                          s_axi_rvalid;
  logic                          s_axi_rready;
  logic [ADDR_WIDTH-1:DATA_BITS] m_al_waddr;
  logic [DATA_WIDTH-1:0]         m_al_wdata;
  logic                          m_al_wvalid;
  logic                          m_al_wready;
  logic [ADDR_WIDTH-1:DATA_BITS] m_al_araddr;
  logic [ID_WIDTH:0]             m_al_arid;
  logic                          m_al_arvalid;
  logic                          m_al_arready;
  logic [DATA_WIDTH-1:0]         m_al_rdata;
  logic [ID_WIDTH:0]             m_al_rid;
  logic                          m_al_rvalid;
  logic                          m_al_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    output m_al_waddr, m_al_wdata, m_al_wvalid,
    input  m_al_wready,
    output m_al_araddr, m_al_arid, m_al_arvalid,
    input  m_al_arready,
    input  m_al_rdata, m_al_rid, m_al_rvalid,
    output m_al_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    input  m_al_waddr, m_al_wdata, m_al_wvalid,
    output m_al_wready,
    input  m_al_araddr, m_al_arid, m_al_arvalid,
    output m_al_arready,
    output m_al_rdata, m_al_rid, m_al_rvalid,
    input  m_al_rready
  );
endinterface

// File: rtl/axi4_to_alrdwr.sv
// AXI4 slave to AL read/write bridge: expands bursts into per-word AL beats,
// builds B responses and carries RLAST through the AL read-ID sideband.
module axi4_to_alrdwr #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_BITS  = 2,
  parameter int ID_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  axi4_to_alrdwr_if.slave  bus
);
  localparam int W = ADDR_WIDTH - DATA_BITS;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_ADDR} r_state_t;

  // WRAP only applies to legal lengths; the low log2(len+1) bits roll over.
  function automatic logic [W-1:0] next_addr(input logic [W-1:0] addr,
                                             input logic [7:0]   len,
                                             input logic [1:0]   burst);
    logic [W-1:0] mask;
    logic [W-1:0] inc;
    mask      = W'(len);
    inc       = addr + 1'b1;
    next_addr = inc;
    if (burst == 2'b00) begin
      next_addr = addr;
    end else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      next_addr = (addr & ~mask) | (inc & mask);
    end
  endfunction

  w_state_t            w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                bvalid_q, bvalid_d;
  logic [W-1:0]        waddr_q, waddr_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  logic [7:0]          wlen_q, wlen_d;
  logic [1:0]          wburst_q, wburst_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                werr_q, werr_d;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wid_d     = wid_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    case (w_state_q)
      W_IDLE: begin
        if (bus.s_axi_awvalid && awready_q) begin
          waddr_d   = bus.s_axi_awaddr[ADDR_WIDTH-1:DATA_BITS];
          wid_d     = bus.s_axi_awid;
          wlen_d    = bus.s_axi_awlen;
          wburst_d  = bus.s_axi_awburst;
          wcnt_d    = 8'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.s_axi_wvalid && bus.m_al_wready) begin
          waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          // The beat count, not wlast, decides where the burst ends.
          if (bus.s_axi_wlast != (wcnt_q == wlen_q)) werr_d = 1'b1;
          if (wcnt_q == wlen_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.s_axi_bready) begin
          werr_d    = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      waddr_q   <= '0;
      wid_q     <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      waddr_q   <= waddr_d;
      wid_q     <= wid_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_wready  = (w_state_q == W_DATA) && bus.m_al_wready;
  assign bus.m_al_wvalid   = (w_state_q == W_DATA) && bus.s_axi_wvalid;
  assign bus.m_al_waddr    = waddr_q;
  assign bus.m_al_wdata    = bus.s_axi_wdata;
  assign bus.s_axi_bid     = wid_q;
  assign bus.s_axi_bresp   = werr_q ? 2'b10 : 2'b00;
  assign bus.s_axi_bvalid  = bvalid_q;

  r_state_t            r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                arvalid_q, arvalid_d;
  logic [W-1:0]        raddr_q, raddr_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]          rlen_q, rlen_d;
  logic [1:0]          rburst_q, rburst_d;
  logic [7:0]          rcnt_q, rcnt_d;

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.s_axi_arvalid && arready_q) begin
          raddr_d   = bus.s_axi_araddr[ADDR_WIDTH-1:DATA_BITS];
          rid_d     = bus.s_axi_arid;
          rlen_d    = bus.s_axi_arlen;
          rburst_d  = bus.s_axi_arburst;
          rcnt_d    = 8'd0;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (bus.m_al_arready) begin
          raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
          rcnt_d  = rcnt_q + 8'd1;
          if (rcnt_q == rlen_q) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    arvalid_d = (r_state_d == R_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      arvalid_q <= 1'b0;
      raddr_q   <= '0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      arvalid_q <= arvalid_d;
      raddr_q   <= raddr_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign bus.s_axi_arready = arready_q;
  assign bus.m_al_arvalid  = arvalid_q;
  assign bus.m_al_araddr   = raddr_q;
  assign bus.m_al_arid     = {rcnt_q == rlen_q, rid_q};

  // Read data needs no state: the last flag rides back in the AL ID MSB.
  assign bus.s_axi_rdata  = bus.m_al_rdata;
  assign bus.s_axi_rid    = bus.m_al_rid[ID_WIDTH-1:0];
  assign bus.s_axi_rlast  = bus.m_al_rid[ID_WIDTH];
  assign bus.s_axi_rresp  = 2'b00;
  assign bus.s_axi_rvalid = bus.m_al_rvalid;
  assign bus.m_al_rready  = bus.s_axi_rready;
endmodule
